// File: rtl/spimemio_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// spimemio_cfg_sequencer
//
// Issues a complete single-lane SPI flash command (opcode followed by 0-4 data
// bytes) by bit-banging csb/clk/do through writes to the spimemio configuration
// register. The cfgreg write port is shared between CPU bus writes (forwarded
// while idle) and the sequencer's own writes. Memory-mapped mode is restored
// from a shadow copy of the enable bit when the sequence completes.
//
// cfgreg fields driven: [31] mm enable, [11:8] oe, [5] csb, [4] clk, [3:0] do.
//
// Ports:
//   clk         system clock
//   resetn      asynchronous active-low reset
//   bus_we      CPU byte write strobes to cfgreg
//   bus_di      CPU write data
//   bus_err     one-cycle pulse, CPU write dropped while busy
//   cmd_valid   command request
//   cmd_ready   command can be accepted this cycle (idle, no bus write)
//   cmd_byte    SPI opcode
//   cmd_nbytes  number of data bytes after the opcode (clamped to 4)
//   cmd_data    data bytes, sent MSB first from [31:24]
//   busy        sequence in progress
//   done        one-cycle pulse in the cycle after the restore write
//   cfgreg_we   registered byte strobes to spimemio
//   cfgreg_di   registered data to spimemio
//
// State table:
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   S_IDLE     | forward bus writes, accept commands
//   S_DIS      | cfgreg[31]=0 written (memory-mapped mode off)
//   S_CS_LO    | csb low, clk low, oe on, do 0
//   S_SHIFT_LO | current bit on do with clk low, held CLK_DIV cycles
//   S_SHIFT_HI | same bit with clk high, held CLK_DIV cycles
//   S_CS_HI    | csb high, oe off
//   S_RESTORE  | cfgreg[31] written back from the shadow enable
// -----------------------------------------------------------------------------
module spimemio_cfg_sequencer #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  bus_we,
    input  logic [31:0] bus_di,
    output logic        bus_err,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_byte,
    input  logic [2:0]  cmd_nbytes,
    input  logic [31:0] cmd_data,
    output logic        busy,
    output logic        done,
    output logic [3:0]  cfgreg_we,
    output logic [31:0] cfgreg_di
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIS,
        S_CS_LO,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_CS_HI,
        S_RESTORE
    } state_t;

    // Each shift state lasts CLK_DIV cycles including its write cycle, so the
    // down-counter starts at CLK_DIV-1 and the state ends at terminal count 0.
    localparam logic [7:0] HOLD_INIT = 8'(CLK_DIV - 1);

    localparam logic [3:0]  WE_EN    = 4'b1000;
    localparam logic [3:0]  WE_PINS  = 4'b0011;
    localparam logic [31:0] DI_CS_LO = 32'h0000_0100;
    localparam logic [31:0] DI_CS_HI = 32'h0000_0020;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [39:0] r_shift;
    logic [5:0]  r_bits;
    logic [7:0]  r_hold;
    logic        r_shadow_en;

    logic [3:0]  r_cfgreg_we;
    logic [31:0] r_cfgreg_di;
    logic        r_done;
    logic        r_bus_err;

    logic        w_bus_req;
    logic        w_accept;
    logic [2:0]  w_nbytes;
    logic [5:0]  w_bits_init;

    logic        w_wr_en;
    logic [3:0]  w_wr_we;
    logic [31:0] w_wr_di;
    logic        w_load_hold;
    logic        w_hold_dec;
    logic        w_shift_adv;

    // Pin word for a shift write: oe=0001, csb=0, clk=sck, do={3'b0,b}.
    function automatic logic [31:0] f_shift_word(input logic sck, input logic b);
        return {20'b0, 4'b0001, 2'b00, 1'b0, sck, 3'b000, b};
    endfunction

    assign w_bus_req   = |bus_we;
    assign cmd_ready   = (r_state == S_IDLE) && !w_bus_req;
    assign w_accept    = cmd_ready && cmd_valid;
    assign w_nbytes    = (cmd_nbytes > 3'd4) ? 3'd4 : cmd_nbytes;
    assign w_bits_init = {w_nbytes, 3'b000} + 6'd8;

    // The write that belongs to a state is computed on the transition into it
    // and registered, so it is visible in the first cycle of that state.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_wr_we     = 4'b0000;
        w_wr_di     = 32'h0000_0000;
        w_load_hold = 1'b0;
        w_hold_dec  = 1'b0;
        w_shift_adv = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_bus_req) begin
                    w_wr_en = 1'b1;
                    w_wr_we = bus_we;
                    w_wr_di = bus_di;
                end else if (cmd_valid) begin
                    w_state_nxt = S_DIS;
                    w_wr_en     = 1'b1;
                    w_wr_we     = WE_EN;
                    w_wr_di     = 32'h0000_0000;
                end
            end

            S_DIS: begin
                w_state_nxt = S_CS_LO;
                w_wr_en     = 1'b1;
                w_wr_we     = WE_PINS;
                w_wr_di     = DI_CS_LO;
            end

            S_CS_LO: begin
                w_state_nxt = S_SHIFT_LO;
                w_wr_en     = 1'b1;
                w_wr_we     = WE_PINS;
                w_wr_di     = f_shift_word(1'b0, r_shift[39]);
                w_load_hold = 1'b1;
            end

            S_SHIFT_LO: begin
                if (r_hold == 8'd0) begin
                    w_state_nxt = S_SHIFT_HI;
                    w_wr_en     = 1'b1;
                    w_wr_we     = WE_PINS;
                    w_wr_di     = f_shift_word(1'b1, r_shift[39]);
                    w_load_hold = 1'b1;
                end else begin
                    w_hold_dec = 1'b1;
                end
            end

            S_SHIFT_HI: begin
                if (r_hold == 8'd0) begin
                    w_shift_adv = 1'b1;
                    w_wr_en     = 1'b1;
                    w_wr_we     = WE_PINS;
                    // r_bits counts the bit on the wire too; one left means
                    // this was the last bit.
                    if (r_bits <= 6'd1) begin
                        w_state_nxt = S_CS_HI;
                        w_wr_di     = DI_CS_HI;
                    end else begin
                        w_state_nxt = S_SHIFT_LO;
                        w_wr_di     = f_shift_word(1'b0, r_shift[38]);
                        w_load_hold = 1'b1;
                    end
                end else begin
                    w_hold_dec = 1'b1;
                end
            end

            S_CS_HI: begin
                w_state_nxt = S_RESTORE;
                w_wr_en     = 1'b1;
                w_wr_we     = WE_EN;
                w_wr_di     = {r_shadow_en, 31'b0};
            end

            S_RESTORE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cfgreg_we <= 4'b0000;
            r_cfgreg_di <= 32'h0000_0000;
            r_done      <= 1'b0;
            r_bus_err   <= 1'b0;
            r_shadow_en <= 1'b1;
            r_shift     <= 40'h0;
            r_bits      <= 6'd0;
            r_hold      <= 8'd0;
        end else begin
            r_cfgreg_we <= w_wr_en ? w_wr_we : 4'b0000;
            if (w_wr_en) begin
                r_cfgreg_di <= w_wr_di;
            end

            r_done    <= (r_state == S_RESTORE);
            r_bus_err <= (r_state != S_IDLE) && w_bus_req;

            // Only forwarded bus writes update the shadow; dropped ones do not.
            if ((r_state == S_IDLE) && bus_we[3]) begin
                r_shadow_en <= bus_di[31];
            end

            // Unused data bits beyond the clamped count are never shifted out.
            if (w_accept) begin
                r_shift <= {cmd_byte, cmd_data};
                r_bits  <= w_bits_init;
            end else if (w_shift_adv) begin
                r_shift <= {r_shift[38:0], 1'b0};
                if (r_bits != 6'd0) begin
                    r_bits <= r_bits - 6'd1;
                end
            end

            if (w_load_hold) begin
                r_hold <= HOLD_INIT;
            end else if (w_hold_dec) begin
                r_hold <= r_hold - 8'd1;
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign bus_err   = r_bus_err;
    assign cfgreg_we = r_cfgreg_we;
    assign cfgreg_di = r_cfgreg_di;

endmodule

// File: tb/tb_spimemio_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for spimemio_cfg_sequencer. Expected cfgreg write streams (cycle,
// strobes, data) are computed from the command bits with plain arithmetic and
// compared against what the design emits. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_spimemio_cfg_sequencer;

    localparam int DIV = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  bus_we = 4'b0;
    logic [31:0] bus_di = 32'h0;
    logic        bus_err;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_byte = 8'h0;
    logic [2:0]  cmd_nbytes = 3'd0;
    logic [31:0] cmd_data = 32'h0;
    logic        busy;
    logic        done;
    logic [3:0]  cfgreg_we;
    logic [31:0] cfgreg_di;

    always #5 clk = ~clk;

    spimemio_cfg_sequencer #(.CLK_DIV(DIV)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus_we     (bus_we),
        .bus_di     (bus_di),
        .bus_err    (bus_err),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_byte   (cmd_byte),
        .cmd_nbytes (cmd_nbytes),
        .cmd_data   (cmd_data),
        .busy       (busy),
        .done       (done),
        .cfgreg_we  (cfgreg_we),
        .cfgreg_di  (cfgreg_di)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic m_shadow = 1'b1;

    int          e_cyc[$];
    logic [3:0]  e_we[$];
    logic [31:0] e_di[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected write list: cycle index counted from the first busy cycle.
    task automatic build_model(input logic [7:0] op, input logic [2:0] n,
                               input logic [31:0] data, output int nbits);
        logic bl[$];
        int   nb;
        int   cyc;
        e_cyc.delete(); e_we.delete(); e_di.delete();
        nb = (n > 4) ? 4 : int'(n);
        for (int i = 7; i >= 0; i--) bl.push_back(op[i]);
        for (int i = 0; i < 8 * nb; i++) bl.push_back(data[31 - i]);
        nbits = bl.size();
        e_cyc.push_back(0); e_we.push_back(4'b1000); e_di.push_back(32'h0);
        e_cyc.push_back(1); e_we.push_back(4'b0011); e_di.push_back(32'h100);
        for (int k = 0; k < 2 * nbits; k++) begin
            e_cyc.push_back(2 + k * DIV);
            e_we.push_back(4'b0011);
            e_di.push_back(32'(256 + 16 * (k % 2) + int'(bl[k / 2])));
        end
        cyc = 2 + 2 * nbits * DIV;
        e_cyc.push_back(cyc);     e_we.push_back(4'b0011); e_di.push_back(32'h20);
        e_cyc.push_back(cyc + 1); e_we.push_back(4'b1000); e_di.push_back({m_shadow, 31'b0});
    endtask

    // Called at a falling edge with the design idle.
    task automatic run_cmd(input logic [7:0] op, input logic [2:0] n, input logic [31:0] data,
                           input int inj, input bit collide, input string nm);
        int          nbits, busy_exp;
        int          nbusy, ndone, done_c, nerr, err_c;
        int          g_cyc[$];
        logic [3:0]  g_we[$];
        logic [31:0] g_di[$];
        logic [31:0] cd;
        nbusy = 0; ndone = 0; done_c = -1; nerr = 0; err_c = -1;
        build_model(op, n, data, nbits);
        busy_exp = 4 + 2 * DIV * nbits;
        cmd_byte = op; cmd_nbytes = n; cmd_data = data; cmd_valid = 1'b1;
        if (collide) begin
            cd = $urandom;
            bus_we = 4'b0001; bus_di = cd;
            #1 chk({nm, "_coll_ready"}, 64'(cmd_ready), 64'd0);
            @(negedge clk);
            chk({nm, "_coll_fwd"}, {28'h0, cfgreg_we, cfgreg_di}, {28'h0, 4'b0001, cd});
            bus_we = 4'b0;
        end else begin
            #1 chk({nm, "_ready"}, 64'(cmd_ready), 64'd1);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 0; c < busy_exp + 8; c++) begin
            if (busy) nbusy++;
            if (cfgreg_we != 4'b0) begin
                g_cyc.push_back(c); g_we.push_back(cfgreg_we); g_di.push_back(cfgreg_di);
            end
            if (done) begin ndone++; if (done_c < 0) done_c = c; end
            if (bus_err) begin nerr++; if (err_c < 0) err_c = c; end
            if (c == inj) begin
                // Try to flip the shadow enable while busy; must be dropped.
                bus_we = 4'b1001;
                bus_di = {~m_shadow, 31'h0} | ($urandom & 32'h7FFF_FFFF);
            end else begin
                bus_we = 4'b0;
            end
            if (done_c >= 0 && c >= done_c + 2) break;
            @(negedge clk);
        end
        bus_we = 4'b0;
        chk({nm, "_busy_len"}, 64'(nbusy), 64'(busy_exp));
        chk({nm, "_done_cyc"}, 64'(done_c), 64'(busy_exp));
        chk({nm, "_done_cnt"}, 64'(ndone), 64'd1);
        chk({nm, "_nwrites"}, 64'(g_cyc.size()), 64'(e_cyc.size()));
        for (int i = 0; i < g_cyc.size() && i < e_cyc.size(); i++) begin
            chk($sformatf("%s_wr%0d", nm, i),
                {g_cyc[i][15:0], 12'h0, g_we[i], g_di[i]},
                {e_cyc[i][15:0], 12'h0, e_we[i], e_di[i]});
        end
        chk({nm, "_err_cnt"}, 64'(nerr), (inj >= 0) ? 64'd1 : 64'd0);
        if (inj >= 0) chk({nm, "_err_cyc"}, 64'(err_c), 64'(inj + 1));
    endtask

    task automatic bus_write(input logic [3:0] we, input logic [31:0] di, input string nm);
        bus_we = we; bus_di = di;
        @(negedge clk);
        chk({nm, "_fwd"}, {28'h0, cfgreg_we, cfgreg_di}, {28'h0, we, di});
        chk({nm, "_err"}, 64'(bus_err), 64'd0);
        bus_we = 4'b0;
        if (we[3]) m_shadow = di[31];
        @(negedge clk);
        chk({nm, "_idle"}, 64'(cfgreg_we), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] rn;
        int         rbits, rinj;
        #12;
        chk("reset_state", {58'h0, cfgreg_we == 4'b0, cfgreg_di == 32'h0, busy, done, bus_err, cmd_ready},
                           {58'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        run_cmd(8'h06, 3'd0, $urandom, -1, 1'b0, "wren");
        run_cmd(8'h01, 3'd7, 32'hA5C3_0FF0, -1, 1'b0, "clamp");
        bus_write(4'b1000, 32'h0000_1234, "shd0");
        run_cmd(8'h31, 3'd1, $urandom, -1, 1'b0, "shd0_cmd");
        run_cmd(8'h05, 3'd2, $urandom, 7, 1'b0, "drop");
        run_cmd(8'h06, 3'd0, $urandom, -1, 1'b1, "coll");
        bus_write(4'b1000, 32'h8000_0000, "shd1");

        // Reset in the middle of shifting, with the shadow cleared beforehand.
        bus_write(4'b1000, 32'h0, "pre_rst");
        cmd_byte = 8'hFF; cmd_nbytes = 3'd3; cmd_data = $urandom; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_pre_busy", 64'(busy), 64'd1);
        resetn = 1'b0;
        #1 chk("rst_async", {59'h0, cfgreg_we == 4'b0, cfgreg_di == 32'h0, busy, done, cmd_ready},
                            {59'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        resetn = 1'b1;
        m_shadow = 1'b1;
        @(negedge clk);
        run_cmd(8'h9F, 3'd1, $urandom, -1, 1'b0, "post_rst");

        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 1) == 1)
                bus_write(4'($urandom_range(1, 15)), $urandom, $sformatf("rbw%0d", it));
            rn = 3'($urandom_range(0, 7));
            rbits = 8 * (1 + ((rn > 4) ? 4 : int'(rn)));
            rinj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 1 + 2 * DIV * rbits)) : -1;
            run_cmd(8'($urandom), rn, $urandom, rinj, 1'($urandom_range(0, 1)),
                    $sformatf("rnd%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
